// File: rtl/riscv_pkg.sv
// Shared core-wide types and constants used by the fetch front end.
package riscv_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ILEN = 32;

  localparam logic [XLEN-1:0] DefaultResetPc = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  // Instruction fetch is word-aligned; low address bits are dropped.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch queue bus: imem request/response, execute redirect and decode handshake.
interface fetch_queue_if import riscv_pkg::*; #(
  parameter int unsigned DEPTH = 4
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] imem_addr;
  logic [ILEN-1:0] imem_rdata;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            deq_valid;
  logic            deq_ready;
  logic [XLEN-1:0] deq_pc;
  logic [ILEN-1:0] deq_instr;
  logic [CntW-1:0] count;

  modport master (
    output imem_addr, deq_valid, deq_pc, deq_instr, count,
    input  imem_rdata, redirect_valid, redirect_pc, deq_ready
  );

  modport slave (
    input  imem_addr, deq_valid, deq_pc, deq_instr, count,
    output imem_rdata, redirect_valid, redirect_pc, deq_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Storage, pointers and occupancy for the fetch queue; flush empties without clearing data.
module fetch_fifo import riscv_pkg::*; #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fetch_entry_t             wr_entry,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  fetch_entry_t    mem_q [DEPTH];
  logic [PtrW-1:0] rd_ptr_q;
  logic [PtrW-1:0] wr_ptr_q;
  logic [PtrW:0]   count_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q    <= '{default: '0};
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= wr_entry;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch buffer: owns the fetch PC, queues {pc, instr} and feeds decode.
module fetch_queue import riscv_pkg::*; #(
  parameter int unsigned    DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = DefaultResetPc
) (
  input  logic         clk,
  input  logic         reset,
  fetch_queue_if.master bus
);

  localparam int unsigned     CntW      = $clog2(DEPTH) + 1;
  localparam logic [CntW-1:0] FullCount = CntW'(DEPTH);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;
  logic            push;
  logic            pop;
  logic            full;
  fetch_entry_t    wr_entry;
  fetch_entry_t    head;
  logic [CntW-1:0] count;

  // No full-bypass: a slot freed this cycle is only refilled next cycle.
  assign full          = (count == FullCount);
  assign push          = !bus.redirect_valid && !full;
  assign bus.deq_valid = (count != '0) && !bus.redirect_valid;
  assign pop           = bus.deq_valid && bus.deq_ready;
  assign wr_entry      = '{pc: pc_q, instr: bus.imem_rdata};

  always_comb begin
    pc_d = pc_q;
    if (bus.redirect_valid) begin
      pc_d = align_pc(bus.redirect_pc);
    end else if (push) begin
      pc_d = pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pop      (pop),
    .flush    (bus.redirect_valid),
    .wr_entry (wr_entry),
    .head     (head),
    .count    (count)
  );

  assign bus.imem_addr = pc_q;
  assign bus.deq_pc    = head.pc;
  assign bus.deq_instr = head.instr;
  assign bus.count     = count;

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: a queue-level fetch model predicts the decode stream.
module tb_fetch_queue;
  import riscv_pkg::*;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] IMEM_KEY = 32'hA5A5_0000;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  fetch_queue_if #(.DEPTH(DEPTH)) bus ();

  fetch_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Combinational imem: each word is its own address xor a key.
  assign bus.imem_rdata = bus.imem_addr ^ IMEM_KEY;

  int total = 0;
  int bad   = 0;

  // Expected decode stream, oldest first: {pc, instr}.
  logic [63:0] sb [$];
  int          msize;
  logic [31:0] mpc;
  bit          known = 1'b0;
  logic [63:0] mon_exp;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Monitor: every accepted dequeue must match the oldest predicted entry.
  always @(negedge clk) begin
    if (known && !reset && bus.deq_valid === 1'b1 && bus.deq_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL deq_unexpected: got pc %h want no entry", bus.deq_pc);
      end else begin
        mon_exp = sb.pop_front();
        check("deq_pc", bus.deq_pc, mon_exp[63:32]);
        check("deq_instr", bus.deq_instr, mon_exp[31:0]);
      end
    end
  end

  // One clock cycle: drive inputs, check visible state, advance the model across the edge.
  task automatic step(input bit rst, input bit redir, input logic [31:0] rpc, input bit rdy);
    bit enq;
    bit deq;
    reset              = rst;
    bus.redirect_valid = redir;
    bus.redirect_pc    = rpc;
    bus.deq_ready      = rdy;
    @(negedge clk);
    #1;
    if (known) begin
      check("deq_valid", 32'(bus.deq_valid), 32'(msize != 0 && !redir));
      check("imem_addr", bus.imem_addr, mpc);
      check("count", 32'(bus.count), 32'(msize));
    end
    if (rst) begin
      sb.delete();
      msize = 0;
      mpc   = RESET_PC;
      known = 1'b1;
    end else if (redir) begin
      sb.delete();
      msize = 0;
      mpc   = rpc & 32'hFFFF_FFFC;
    end else begin
      deq = (msize != 0) && rdy;
      enq = msize < DEPTH;
      if (enq) begin
        sb.push_back({mpc, mpc ^ IMEM_KEY});
        mpc = mpc + 32'd4;
      end
      msize = msize + int'(enq) - int'(deq);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset              = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.deq_ready      = 1'b0;

    step(1, 0, 0, 0);
    step(1, 0, 0, 0);

    // Decode stalled: the queue fills and fetch stops at 0x10.
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0);
    check("full_count", 32'(bus.count), 32'd4);
    check("full_addr", bus.imem_addr, 32'h10);

    // One dequeue from full: no refill in the same cycle.
    step(0, 0, 0, 1);
    check("no_bypass_count", 32'(bus.count), 32'd3);
    step(0, 0, 0, 0);
    check("refill_count", 32'(bus.count), 32'd4);
    check("refill_addr", bus.imem_addr, 32'h14);

    // Redirect while three entries are queued.
    step(0, 0, 0, 1);
    step(0, 1, 32'h0000_0103, 1);
    check("redir_count", 32'(bus.count), 32'd0);
    check("redir_addr", bus.imem_addr, 32'h100);
    step(0, 0, 0, 0);
    bus.deq_ready = 1'b0;
    #1;
    check("redir_deq_pc", bus.deq_pc, 32'h100);

    // Steady streaming.
    for (int i = 0; i < 10; i++) step(0, 0, 0, 1);

    // PC wraps past the top of the address space.
    step(0, 1, 32'hFFFF_FFF8, 1);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1);

    // Reset wins over a simultaneous redirect with two entries queued.
    step(0, 1, 32'h0000_0040, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check("pre_reset_count", 32'(bus.count), 32'd2);
    step(1, 1, 32'h0000_0500, 1);
    bus.redirect_valid = 1'b0;
    bus.deq_ready      = 1'b0;
    reset              = 1'b0;
    #1;
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_deq_valid", 32'(bus.deq_valid), 32'd0);
    check("rst_addr", bus.imem_addr, RESET_PC);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] rpc;
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                       : $urandom;
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) == 0), rpc,
           ($urandom_range(0, 3) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction prefetch buffer between the instruction memory (imem) and the decode stage of the pipelined RISC-V core.
- Owns the fetch PC and drives the imem address. Captures each returned instruction word together with its PC into a small FIFO.
- Presents the FIFO head to decode through a valid/ready handshake, so decode stalls do not stall fetch until the queue fills.
- Branch/jump redirects from execute flush the queue and reload the fetch PC.

Parameters:
- DEPTH, 4, number of queue entries; power of two, minimum 2.
- RESET_PC, 32'h0000_0000, fetch PC loaded on reset; must be 4-byte aligned.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- imem_addr  output  32  current fetch PC (pc_q); the top level slices the word index for imem.
- imem_rdata  input  32  instruction word at imem_addr, valid in the same cycle (combinational imem).
- redirect_valid  input  1  execute-stage redirect (taken branch, jump, or mispredict).
- redirect_pc  input  32  redirect target; bits [1:0] are ignored and forced to 0.
- deq_valid  output  1  head entry available to decode.
- deq_ready  input  1  decode accepts the head entry this cycle (not stalled).
- deq_pc  output  32  PC of the head entry.
- deq_instr  output  32  instruction word of the head entry.
- count  output  $clog2(DEPTH)+1  number of occupied entries.

Behaviour:
- Reset (reset=1 at a clock edge):
  - pc_q <= RESET_PC; rd_ptr, wr_ptr and count <= 0; all storage entries <= 0.
  - After the edge: deq_valid=0, deq_pc=0, deq_instr=0, count=0, imem_addr=RESET_PC.
  - Reset overrides redirect and handshake activity in the same cycle. Reset mid-stream discards all entries.
- Enqueue, when !redirect_valid && count<DEPTH:
  - Write {pc_q, imem_rdata} at wr_ptr.
  - wr_ptr <= wr_ptr+1 (mod DEPTH, natural wrap); pc_q <= pc_q+4 (32-bit wrap, 32'hFFFF_FFFC -> 0).
- Full (count==DEPTH): no enqueue and pc_q holds, even if a dequeue occurs that cycle. There is no full-bypass; the freed slot is refilled the next cycle.
- Dequeue, when deq_valid && deq_ready: rd_ptr <= rd_ptr+1 (mod DEPTH).
- deq_valid = (count!=0) && !redirect_valid.
  - This is the only combinational input-to-output path; no dequeue is possible in a redirect cycle.
- deq_pc and deq_instr always show storage[rd_ptr]; their value is don't-care when deq_valid=0.
- Count update:
  - +1 on enqueue only; -1 on dequeue only; unchanged on both or neither.
  - Never exceeds DEPTH; never underflows.
- Redirect (redirect_valid=1, reset=0):
  - rd_ptr, wr_ptr, count <= 0; pc_q <= {redirect_pc[31:2], 2'b00}.
  - No enqueue or dequeue occurs that cycle.
- Latency:
  - The instruction fetched in cycle N is visible at deq in cycle N+1 (1-cycle fetch-to-decode latency).
  - After a redirect in cycle N, the target instruction is fetched in N+1 and presented in N+2.
- Back-to-back redirects: the last redirect wins; the queue stays empty while redirect_valid is held.
- Steady state with deq_ready=1: one instruction per cycle, count settles at 1.

Decomposition:
- Shared package riscv_pkg provides:
  - XLEN=32, ILEN=32.
  - Typedef fetch_entry_t (packed struct {logic [XLEN-1:0] pc; logic [ILEN-1:0] instr;}).
  - Default RESET_PC constant.
- Sub-module fetch_fifo holds the storage array, rd/wr pointers and count, with push/pop/flush inputs. fetch_queue keeps the PC register, enqueue/redirect control and the handshake gating.

Test Plan:
- Reset, then deq_ready=1 and imem returning word = addr^32'hA5A5_0000 -> deq stream (pc, instr) = (0, 0xA5A5_0000), (4, 0xA5A5_0004), (8, 0xA5A5_0008)…; first deq_valid one cycle after reset deasserts.
- deq_ready=0 for 10 cycles after reset (DEPTH=4) -> count reaches 4 and holds; imem_addr stops at 0x10. Raise deq_ready -> PCs 0,4,8,C,10 delivered in order; count never exceeds 4.
- Queue full (count=4), then deq_ready=1 for one cycle -> count=3 next cycle (no bypass refill), back to 4 the cycle after; imem_addr advances to 0x14.
- Redirect in cycle N with redirect_pc=0x0000_0103 while count=3 -> deq_valid=0 in cycle N; count=0 at N+1; imem_addr=0x100 at N+1; deq_pc=0x100 at N+2.
- pc_q forced near the top via redirect_pc=0xFFFF_FFF8 -> delivered PCs FFFF_FFF8, FFFF_FFFC, 0000_0000 (wrap).
- Assert reset for one cycle while count=2 and redirect_valid=1 -> next cycle count=0, deq_valid=0, imem_addr=RESET_PC (reset overrides redirect).
